pixel_packetizer: RTL and testbench

Frames CCD pixel samples into a byte stream for the host link. Accepts 16-bit pixels on a valid/ready handshake, wraps each frame in a header and a checksum trailer, and writes bytes into the TX FIFO. The FT245 bridge drains that FIFO to the FTDI device. Runs in the pixel/ADC clock domain, upstream of the TX FIFO write port.

---
 rtl/pixel_packetizer_pkg.sv | 21 ++
 rtl/pixel_packetizer.sv | 140 ++++++++++++++
 tb/tb_pixel_packetizer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pixel_packetizer_pkg.sv
// Shared CCD-side constants: sync bytes, default frame size and packetizer state encoding.
// Other CCD blocks import this package to stay byte-compatible with the host link.
package pixel_packetizer_pkg;

  localparam int unsigned NPIX_DEFAULT  = 1024;
  localparam logic [7:0]  SYNC0_DEFAULT = 8'hA5;
  localparam logic [7:0]  SYNC1_DEFAULT = 8'h5A;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_HDR0   = 4'd1,
    ST_HDR1   = 4'd2,
    ST_FID    = 4'd3,
    ST_CNT_HI = 4'd4,
    ST_CNT_LO = 4'd5,
    ST_PIX_HI = 4'd6,
    ST_PIX_LO = 4'd7,
    ST_CSUM   = 4'd8
  } pkt_state_t;

endpackage

// File: rtl/pixel_packetizer.sv
// Frames 16-bit pixels into SYNC0 SYNC1 FID NPIX_HI NPIX_LO <pixels hi/lo> CSUM bytes
// for the TX FIFO; the checksum is the XOR of the pixel bytes only.
module pixel_packetizer
  import pixel_packetizer_pkg::*;
#(
  parameter int unsigned NPIX  = NPIX_DEFAULT,
  parameter logic [7:0]  SYNC0 = SYNC0_DEFAULT,
  parameter logic [7:0]  SYNC1 = SYNC1_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        pixel_valid,
  input  logic [15:0] pixel_data,
  output logic        pixel_ready,
  output logic [7:0]  tx_wdata,
  output logic        tx_winc,
  input  logic        tx_wfull,
  output logic        busy,
  output logic        frame_dropped
);

  localparam logic [15:0] NPIX_W = 16'(NPIX);

  pkt_state_t  state_reg, state_next;
  logic [7:0]  frame_id_reg;
  logic [7:0]  csum_reg;
  logic [15:0] pix_cnt_reg;
  logic [7:0]  lo_byte_reg;
  logic        dropped_reg;

  always_comb begin
    state_next  = state_reg;
    tx_winc     = 1'b0;
    tx_wdata    = 8'h00;
    pixel_ready = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (frame_start) state_next = ST_HDR0;
      end
      ST_HDR0: begin
        tx_wdata = SYNC0;
        if (!tx_wfull) begin
          tx_winc    = 1'b1;
          state_next = ST_HDR1;
        end
      end
      ST_HDR1: begin
        tx_wdata = SYNC1;
        if (!tx_wfull) begin
          tx_winc    = 1'b1;
          state_next = ST_FID;
        end
      end
      ST_FID: begin
        tx_wdata = frame_id_reg;
        if (!tx_wfull) begin
          tx_winc    = 1'b1;
          state_next = ST_CNT_HI;
        end
      end
      ST_CNT_HI: begin
        tx_wdata = NPIX_W[15:8];
        if (!tx_wfull) begin
          tx_winc    = 1'b1;
          state_next = ST_CNT_LO;
        end
      end
      ST_CNT_LO: begin
        tx_wdata = NPIX_W[7:0];
        if (!tx_wfull) begin
          tx_winc    = 1'b1;
          state_next = ST_PIX_HI;
        end
      end
      ST_PIX_HI: begin
        // The hi byte goes straight from the input; the lo byte is parked for the next cycle.
        pixel_ready = ~tx_wfull;
        tx_wdata    = pixel_data[15:8];
        if (pixel_valid && !tx_wfull) begin
          tx_winc    = 1'b1;
          state_next = ST_PIX_LO;
        end
      end
      ST_PIX_LO: begin
        tx_wdata = lo_byte_reg;
        if (!tx_wfull) begin
          tx_winc    = 1'b1;
          state_next = (pix_cnt_reg == NPIX_W) ? ST_CSUM : ST_PIX_HI;
        end
      end
      ST_CSUM: begin
        tx_wdata = csum_reg;
        if (!tx_wfull) begin
          tx_winc    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      frame_id_reg <= 8'h00;
      csum_reg     <= 8'h00;
      pix_cnt_reg  <= 16'h0000;
      lo_byte_reg  <= 8'h00;
      dropped_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      dropped_reg <= frame_start && (state_reg != ST_IDLE);
      case (state_reg)
        ST_IDLE: begin
          csum_reg    <= 8'h00;
          pix_cnt_reg <= 16'h0000;
        end
        ST_PIX_HI: begin
          if (pixel_valid && !tx_wfull) begin
            csum_reg    <= csum_reg ^ pixel_data[15:8];
            lo_byte_reg <= pixel_data[7:0];
            pix_cnt_reg <= pix_cnt_reg + 16'd1;
          end
        end
        ST_PIX_LO: begin
          if (!tx_wfull) csum_reg <= csum_reg ^ lo_byte_reg;
        end
        ST_CSUM: begin
          if (!tx_wfull) frame_id_reg <= frame_id_reg + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state_reg != ST_IDLE);
  assign frame_dropped = dropped_reg;

endmodule

// File: tb/tb_pixel_packetizer.sv
// Directed bench for pixel_packetizer with NPIX=4: nominal, stalled, dropped-start,
// early-valid, mid-frame reset and 257 back-to-back frames.
module tb_pixel_packetizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic        pixel_valid;
  logic [15:0] pixel_data;
  logic        pixel_ready;
  logic [7:0]  tx_wdata;
  logic        tx_winc;
  logic        tx_wfull;
  logic        busy;
  logic        frame_dropped;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] pix_tab [4] = '{16'h1234, 16'hABCD, 16'h0001, 16'hFF00};

  pixel_packetizer #(.NPIX(4)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .pixel_valid(pixel_valid), .pixel_data(pixel_data), .pixel_ready(pixel_ready),
    .tx_wdata(tx_wdata), .tx_winc(tx_winc), .tx_wfull(tx_wfull),
    .busy(busy), .frame_dropped(frame_dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Entered and left at posedge+#1. Runs one NPIX=4 frame and checks it end to end.
  task automatic run_frame(input bit stall_en, input bit drop_en, input bit valid_early,
                           input logic [7:0] fid);
    logic [7:0] got[$];
    logic [7:0] exp_b [14];
    int hs = 0, cyc = 0, first = -1, last = -1;
    int wf_bad = 0, rdy_bad = 0, drops = 0, stall_left = 0;
    bit s1 = 0, s2 = 0, drop_sent = 0;
    exp_b = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h04, 8'h12, 8'h34,
              8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'h00, 8'hBE};
    exp_b[2] = fid;
    frame_start = 1'b1;
    pixel_valid = valid_early;
    pixel_data  = pix_tab[0];
    tx_wfull    = 1'b0;
    while (got.size() < 14 && cyc < 300) begin
      @(negedge clk);
      if (tx_winc) begin
        got.push_back(tx_wdata);
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (tx_winc && tx_wfull) wf_bad++;
      if (pixel_ready && tx_wfull) rdy_bad++;
      if (frame_dropped) drops++;
      if (pixel_valid && pixel_ready) hs++;
      @(posedge clk); #1;
      cyc++;
      frame_start = 1'b0;
      if (drop_en && !drop_sent && got.size() == 7) begin
        frame_start = 1'b1;
        drop_sent   = 1'b1;
      end
      pixel_valid = (hs < 4) ? (valid_early || got.size() >= 5) : valid_early;
      pixel_data  = pix_tab[(hs < 4) ? hs : 3];
      if (stall_en && !s1 && got.size() == 1) begin s1 = 1; stall_left = 3; end
      if (stall_en && !s2 && got.size() == 6) begin s2 = 1; stall_left = 3; end
      tx_wfull = (stall_left > 0);
      if (stall_left > 0) stall_left--;
    end
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    tx_wfull    = 1'b0;
    @(negedge clk);
    if (frame_dropped) drops++;
    chk("byte_count", got.size(), 14);
    for (int i = 0; i < 14; i++)
      if (i < got.size()) chk($sformatf("byte%0d_fid%02h", i, fid), got[i], exp_b[i]);
    chk("handshakes", hs, 4);
    chk("winc_while_full", wf_bad, 0);
    chk("ready_while_full", rdy_bad, 0);
    chk("dropped_pulses", drops, drop_en ? 1 : 0);
    chk("busy_after", busy, 0);
    if (!stall_en) begin
      chk("first_winc_cycle", first, 1);
      chk("last_winc_cycle", last, 14);
    end
    $display("frame fid=%02h stall=%0b drop=%0b early=%0b bytes=%0d handshakes=%0d",
             fid, stall_en, drop_en, valid_early, got.size(), hs);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    pixel_data  = 16'h0000;
    tx_wfull    = 1'b0;
    #12;
    chk("rst_tx_winc", tx_winc, 0);
    chk("rst_tx_wdata", tx_wdata, 0);
    chk("rst_pixel_ready", pixel_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_dropped", frame_dropped, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame(0, 0, 0, 8'h00);
    run_frame(1, 0, 0, 8'h01);
    run_frame(0, 1, 0, 8'h02);
    run_frame(0, 0, 1, 8'h03);

    // Abort mid-pixel: outputs must fall to reset values without a clock edge.
    frame_start = 1'b1;
    pixel_valid = 1'b1;
    pixel_data  = 16'h5555;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_reset_busy", busy, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_tx_winc", tx_winc, 0);
    chk("async_rst_tx_wdata", tx_wdata, 0);
    chk("async_rst_pixel_ready", pixel_ready, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_frame_dropped", frame_dropped, 0);
    pixel_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // frame_id restarts at 00 after the abort, then wraps FF -> 00.
    for (int i = 0; i < 257; i++) run_frame(0, 0, 0, i[7:0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
